hazard_sequencer: RTL

Central pipeline-control FSM for the 5-stage core. It combines load-use hazard detection, branch-mispredict flush and the multi-cycle EX-unit (mul/div) handshake into one prioritised set of stage enables, flushes and bubble selects. It sits beside the IF/ID and ID/EX pipeline registers and drives the PC enable, pipeline-register enables and the control-signal mux select. Saturating stall/flush counters and a sticky error flag provide observability.

---
 rtl/hazard_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage core: load-use stall, mispredict flush, mul/div wait.
// Stage controls are combinational from state and inputs; counters and err are registered.
module hazard_sequencer #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16,
   parameter int MC_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic                  if_id_use_rs1,
   input  logic                  if_id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_mem_read,
   input  logic                  id_ex_mc_op,
   input  logic                  ex_mispredict,
   input  logic                  mc_done,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ctrl_sel,
   output logic                  mc_start,
   output logic                  ex_hold,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic                  err
);

   localparam int WAIT_W = $clog2(MC_TIMEOUT + 1);

   typedef enum logic {RUN, MC_WAIT} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lu;
   logic              timeout;
   logic              release_mc;

   assign lu = id_ex_mem_read && (id_ex_rd != '0) &&
               ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

   // Timeout releases on the MC_WAIT cycle after MC_TIMEOUT full wait cycles.
   assign timeout    = (state == MC_WAIT) && (wait_cnt == WAIT_W'(MC_TIMEOUT));
   assign release_mc = (state == MC_WAIT) && (mc_done || timeout);

   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ctrl_sel    = 1'b1;
      mc_start    = 1'b0;
      ex_hold     = 1'b0;
      case (state)
         RUN: begin
            if (ex_mispredict) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (id_ex_mc_op) begin
               mc_start = 1'b1;
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               ex_hold  = 1'b1;
            end else if (lu) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               ctrl_sel = 1'b0;
            end
         end
         MC_WAIT: begin
            if (!release_mc) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               ex_hold  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ex_mispredict) begin
                  if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
               end else if (id_ex_mc_op) begin
                  state    <= MC_WAIT;
                  wait_cnt <= '0;
                  if (mc_done) err <= 1'b1;
               end
            end
            MC_WAIT: begin
               if (ex_mispredict) err <= 1'b1;
               if (release_mc) begin
                  state <= RUN;
                  if (!mc_done) err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
         if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
